instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 0.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, cycles allowed in FETCH without imem_valid; range 1..255.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: imem_req  output  1  instruction memory read request.
REQ-006 Port: imem_addr  output  32  byte address of requested word (equals pc).
REQ-007 Port: imem_rdata  input  32  instruction word returned by memory.
REQ-008 Port: imem_valid  input  1  imem_rdata valid this cycle.
REQ-009 Port: instruction  output  32  word presented to the control decoder.
REQ-010 Port: instr_valid  output  1  instruction holds a fetched word.
REQ-011 Port: instr_ready  input  1  decoder/datapath accepts instruction this cycle.
REQ-012 Port: jump  input  1  Jump control from decoder, sampled at accept.
REQ-013 Port: branch  input  1  Branch control from decoder, sampled at accept.
REQ-014 Port: alu_zero  input  1  ALU zero flag, sampled at accept.
REQ-015 Port: pc  output  32  address of the current instruction.
REQ-016 Port: fault  output  1  fetch timeout occurred; sticky.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, ISSUE, UPDATE, FAULT.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-019 In FETCH imem_req SHALL be 1 and imem_addr SHALL equal pc; it SHALL be 0 in all other states.
REQ-020 FETCH with imem_valid=1 SHALL latch imem_rdata into the instruction register and go to ISSUE next cycle.
REQ-021 imem_valid SHALL be ignored outside FETCH.
REQ-022 In ISSUE instr_valid SHALL be 1 and instruction SHALL hold the latched word, stable until accepted.
REQ-023 When instr_valid=0, instruction SHALL equal 32'hFC00_0000 (opcode 6'b111111, decoder idle).
REQ-024 Accept = ISSUE and instr_ready=1; on accept, jump, branch and alu_zero SHALL be registered and state SHALL go to UPDATE.
REQ-025 UPDATE SHALL last one cycle, load pc with next_pc, then go to FETCH.
REQ-026 next_pc: jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch=1 and alu_zero=1 -> pc_plus4 + (sign_extend(instr[15:0]) << 2); else pc_plus4.
REQ-027 jump SHALL take priority when jump and branch are both 1.
REQ-028 pc_plus4 = pc + 4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000; branch target arithmetic SHALL also wrap modulo 2^32.
REQ-029 pc[1:0] SHALL always be 2'b00.
REQ-030 Minimum throughput SHALL be one instruction per 3 cycles (FETCH, ISSUE, UPDATE) with zero-wait memory and instr_ready held 1.

Reset
REQ-031 Reset SHALL asynchronously force state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instruction=32'hFC00_0000, fault=0, timeout counter=0, registered jump/branch/zero=0.
REQ-032 Reset asserted mid-FETCH SHALL drop imem_req immediately; a late imem_valid after release SHALL be ignored unless the block is in FETCH again.
REQ-033 Reset SHALL be the only exit from FAULT.

Configuration
REQ-034 With FETCH_TIMEOUT_EN defined, a counter SHALL clear on FETCH entry, increment each FETCH cycle without imem_valid, and on reaching TIMEOUT_CYCLES move to FAULT, setting fault=1 and imem_req=0; imem_valid arriving in the same cycle as the limit SHALL win (normal latch, no fault).
REQ-035 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, fault SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-036 Reset release, zero-wait memory returns 32'h2008_0005, instr_ready=1 -> imem_addr 0, 32'h4, 32'h8 on successive FETCH cycles, 3 cycles per instruction.
REQ-037 Word 32'h0800_0010 accepted with jump=1 at pc=32'h0000_0040 -> next imem_addr=32'h0000_0040.
REQ-038 Word 32'h1000_FFFE with branch=1, alu_zero=1 at pc=32'h100 -> next pc=32'hFC; with alu_zero=0 -> 32'h104.
REQ-039 instr_ready held 0 for 5 cycles in ISSUE -> instruction and instr_valid stable, no imem_req; pc=32'hFFFF_FFFC accepted, no jump/branch -> next pc=32'h0.
REQ-040 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_valid never asserted -> fault=1 after 4 FETCH cycles, imem_req=0, held until reset; reset mid-FETCH -> imem_req=0 same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch, hold-until-accept issue, and jump/branch next-PC update.
// Optional fetch watchdog is compiled in when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic        fault
);
    localparam logic [29:0] RESET_PC_WORD = RESET_PC[31:2];
    localparam logic [31:0] IDLE_WORD     = 32'hFC00_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        UPDATE = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_word_q, pc_word_d;
    logic [31:0] instr_word_q, instr_word_d;
    logic [31:0] instruction_q, instruction_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        jump_q, jump_d;
    logic        branch_q, branch_d;
    logic        zero_q, zero_d;
    logic        timeout_hit;

    // The PC is held as a word address so the two low bits can never be nonzero
    // and all +4 / offset arithmetic wraps modulo 2^32 for free.
    logic [29:0] pc_word_plus1;
    logic [29:0] branch_word_off;
    logic [29:0] next_pc_word;

    always_comb begin
        pc_word_plus1   = pc_word_q + 30'd1;
        branch_word_off = {{14{instr_word_q[15]}}, instr_word_q[15:0]};
        if (jump_q) begin
            next_pc_word = {pc_word_plus1[29:26], instr_word_q[25:0]};
        end else if (branch_q && zero_q) begin
            next_pc_word = pc_word_plus1 + branch_word_off;
        end else begin
            next_pc_word = pc_word_plus1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_word_d    = pc_word_q;
        instr_word_d = instr_word_q;
        jump_d       = jump_q;
        branch_d     = branch_q;
        zero_d       = zero_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // A word arriving on the limit cycle wins over the timeout.
                if (imem_valid) begin
                    instr_word_d = imem_rdata;
                    state_d      = ISSUE;
                end else if (timeout_hit) begin
                    state_d = FAULT;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    jump_d   = jump;
                    branch_d = branch;
                    zero_d   = alu_zero;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                pc_word_d = next_pc_word;
                state_d   = FETCH;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        imem_req_d    = (state_d == FETCH);
        instr_valid_d = (state_d == ISSUE);
        instruction_d = (state_d == ISSUE) ? instr_word_d : IDLE_WORD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_word_q     <= RESET_PC_WORD;
            instr_word_q  <= IDLE_WORD;
            instruction_q <= IDLE_WORD;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            jump_q        <= 1'b0;
            branch_q      <= 1'b0;
            zero_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_word_q     <= pc_word_d;
            instr_word_q  <= instr_word_d;
            instruction_q <= instruction_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            jump_q        <= jump_d;
            branch_q      <= branch_d;
            zero_q        <= zero_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       fault_q, fault_d;

    // The counter sits at zero outside FETCH, so every FETCH entry starts a fresh count.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (state_q != FETCH) begin
            tmo_cnt_d = 8'd0;
        end else if (!imem_valid) begin
            if (tmo_cnt_q == TIMEOUT_LAST) begin
                timeout_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
        end
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= 8'd0;
            fault_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            fault_q   <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    // Without the watchdog FETCH waits forever; fault is constant 0 for any legal TIMEOUT_CYCLES.
    assign timeout_hit = 1'b0;
    assign fault       = (TIMEOUT_CYCLES == 0);
`endif

    assign imem_req    = imem_req_q;
    assign imem_addr   = {pc_word_q, 2'b00};
    assign pc          = {pc_word_q, 2'b00};
    assign instr_valid = instr_valid_q;
    assign instruction = instruction_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetch addresses and issued words are queued
// when stimulus is set up and popped when the DUT fetches or hands an instruction over.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] pc;
    logic        fault;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump       (jump),
        .branch     (branch),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .fault      (fault)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_fetch_cyc = -1;
    int          rel_cyc = 0;
    bit          gap_chk = 1'b0;
    logic        mem_en = 1'b1;
    logic        force_valid = 1'b0;
    logic [31:0] cur_word = 32'h2008_0005;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive the memory, score any fetch handshake or accept due at the coming edge, then advance.
    task automatic cycle();
        logic [31:0] e;
        #1;
        imem_rdata = cur_word;
        imem_valid = force_valid | (mem_en & imem_req);
        #1;
        if (imem_req && imem_valid) begin
            n_cmp++;
            assert (exp_addr_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_fetch observed_addr=%h expected=no_fetch", imem_addr);
            end
            if (exp_addr_q.size() != 0) begin
                e = exp_addr_q.pop_front();
                check("imem_addr", imem_addr, e);
                check("pc_eq_addr", pc, e);
                if (gap_chk && last_fetch_cyc >= 0)
                    check("fetch_gap", 32'(cyc - last_fetch_cyc), 32'd3);
                $display("fetch  cyc=%0d addr=%h word=%h", cyc, imem_addr, imem_rdata);
            end
            last_fetch_cyc = cyc;
        end
        if (instr_valid && instr_ready) begin
            if (exp_instr_q.size() != 0) begin
                e = exp_instr_q.pop_front();
                check("instruction", instruction, e);
                $display("accept cyc=%0d pc=%h instr=%h j=%b b=%b z=%b", cyc, pc, instruction, jump, branch, alu_zero);
            end else begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_accept observed=%h expected=no_accept", instruction);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [31:0] addr, input logic [31:0] word,
                             input logic j, input logic b, input logic z);
        int n;
        cur_word = word;
        jump     = j;
        branch   = b;
        alu_zero = z;
        exp_addr_q.push_back(addr);
        exp_instr_q.push_back(word);
        n = 0;
        while (exp_instr_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        n_cmp++;
        assert (exp_instr_q.size() == 0) else begin
            n_err++;
            $error("FAIL accept_timeout observed_pending=%0d expected=0 addr=%h", exp_instr_q.size(), addr);
            exp_addr_q.delete();
            exp_instr_q.delete();
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instruction", instruction, 32'hFC00_0000);
        check("rst_pc", pc, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        // Zero-wait streaming from reset: one fetch every 3 cycles, IDLE lasts one cycle.
        reset   = 1'b0;
        rel_cyc = cyc;
        gap_chk = 1'b1;
        run_instr(32'h0, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
        check("idle_one_cycle", 32'(last_fetch_cyc - rel_cyc), 32'd1);
        run_instr(32'h4, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
        run_instr(32'h8, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
        gap_chk = 1'b0;

        // Jumps, jump-over-branch priority, taken and untaken branches.
        run_instr(32'hC,   32'h0800_0010, 1'b1, 1'b0, 1'b0);
        run_instr(32'h40,  32'h0800_0010, 1'b1, 1'b0, 1'b0);
        run_instr(32'h40,  32'h0800_0040, 1'b1, 1'b1, 1'b1);
        run_instr(32'h100, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1);
        run_instr(32'hFC,  32'h0800_0040, 1'b1, 1'b0, 1'b0);
        run_instr(32'h100, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0);

        // Stall in ISSUE with a stray imem_valid; the branch then wraps backwards to 0xFFFF_FFFC.
        instr_ready = 1'b0;
        cur_word    = 32'h1000_FFBD;
        jump = 1'b0; branch = 1'b1; alu_zero = 1'b1;
        exp_addr_q.push_back(32'h104);
        exp_instr_q.push_back(32'h1000_FFBD);
        n = 0;
        while (!instr_valid && n < 10) begin
            cycle();
            n++;
        end
        force_valid = 1'b1;
        cur_word    = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_instruction", instruction, 32'h1000_FFBD);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        force_valid = 1'b0;
        instr_ready = 1'b1;
        n = 0;
        while (exp_instr_q.size() != 0 && n < 5) begin
            cycle();
            n++;
        end
        check("stall_accepted", 32'(exp_instr_q.size()), 32'd0);
        run_instr(32'hFFFF_FFFC, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0, 32'h2008_0005, 1'b0, 1'b0, 1'b0);

        // Memory goes silent in FETCH.
        mem_en = 1'b0;
        cycle();
`ifdef FETCH_TIMEOUT_EN
        repeat (3) cycle();
        check("tmo_req_before", {31'd0, imem_req}, 32'd1);
        check("tmo_fault_before", {31'd0, fault}, 32'd0);
        cycle();
        check("tmo_fault", {31'd0, fault}, 32'd1);
        check("tmo_req_dropped", {31'd0, imem_req}, 32'd0);
        mem_en = 1'b1;
        repeat (5) cycle();
        check("tmo_fault_sticky", {31'd0, fault}, 32'd1);
        check("tmo_req_sticky", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        cycle();
        reset  = 1'b0;
        mem_en = 1'b0;
        cycle();
        repeat (3) cycle();
        mem_en   = 1'b1;
        cur_word = 32'h2008_0005;
        jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back(32'h2008_0005);
        cycle();
        check("limit_valid_wins_fault", {31'd0, fault}, 32'd0);
        check("limit_valid_wins_issue", {31'd0, instr_valid}, 32'd1);
        cycle();
        check("limit_accepted", 32'(exp_instr_q.size()), 32'd0);
`else
        repeat (12) cycle();
        check("wait_req_held", {31'd0, imem_req}, 32'd1);
        check("wait_no_fault", {31'd0, fault}, 32'd0);
        check("wait_pc", pc, 32'h4);
        mem_en = 1'b1;
        run_instr(32'h4, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of FETCH, then a late imem_valid while in IDLE.
        mem_en = 1'b0;
        cycle();
        check("pre_reset_req", {31'd0, imem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        cycle();
        reset       = 1'b0;
        force_valid = 1'b1;
        cur_word    = 32'hDEAD_BEEF;
        cycle();
        force_valid = 1'b0;
        cycle();
        check("late_valid_ignored_instr", instruction, 32'hFC00_0000);
        check("late_valid_ignored_valid", {31'd0, instr_valid}, 32'd0);
        check("refetch_req", {31'd0, imem_req}, 32'd1);
        mem_en = 1'b1;
        run_instr(32'h0, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
        check("queues_drained", 32'(exp_addr_q.size() + exp_instr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
